output_buffer: RTL and testbench

// - Squeeze-side output datapath of the SHAKE core, directly downstream of the permutation state and under control of dump_fsm.
// - Parallel-loads one rate block of Keccak state and shifts it out one W-bit word per accepted cycle.
// - Tracks the remaining word count (drives output_buffer_empty back to dump_fsm) and generates a byte-keep mask for a truncated last block.

---
 rtl/output_buffer_if.sv | 33 +++
 rtl/output_buffer.sv | 75 +++++++
 tb/tb_output_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/output_buffer_if.sv
// Squeeze-side output buffer bus: dump_fsm controls plus the word/keep/last stream.
// master = controller/consumer side, slave = output_buffer.
interface output_buffer_if #(
   parameter int W          = 64,
   parameter int RATE_WORDS = 21
);
   localparam int BYTES_W = $clog2(RATE_WORDS * W / 8 + 1);

   logic [RATE_WORDS*W-1:0] state_in;
   logic                    output_buffer_we;
   logic                    output_counter_load;
   logic                    output_counter_rst;
   logic                    output_buffer_shift_en;
   logic                    valid_bytes_enable;
   logic                    valid_bytes_reset;
   logic [BYTES_W-1:0]      last_bytes_in;
   logic                    output_buffer_empty;
   logic [W-1:0]            data_out;
   logic [W/8-1:0]          keep_out;
   logic                    last_out;

   modport master (
      output state_in, output_buffer_we, output_counter_load, output_counter_rst,
      output output_buffer_shift_en, valid_bytes_enable, valid_bytes_reset, last_bytes_in,
      input  output_buffer_empty, data_out, keep_out, last_out
   );

   modport slave (
      input  state_in, output_buffer_we, output_counter_load, output_counter_rst,
      input  output_buffer_shift_en, valid_bytes_enable, valid_bytes_reset, last_bytes_in,
      output output_buffer_empty, data_out, keep_out, last_out
   );
endinterface

// File: rtl/output_buffer.sv
// output_buffer: loads one rate block, shifts it out a word per accepted cycle, flags/masks the final word.
// Build option OUTPUT_BUFFER_ZERO_PAD_EN: bytes outside keep_out are driven as 0x00 on data_out.
module output_buffer #(
   parameter int W          = 64,
   parameter int RATE_WORDS = 21
) (
   input  logic           clk,
   input  logic           rst,
   output_buffer_if.slave bus
);
   localparam int CNT_W      = $clog2(RATE_WORDS + 1);
   localparam int RATE_BYTES = RATE_WORDS * W / 8;
   localparam int BYTES_W    = $clog2(RATE_BYTES + 1);
   localparam int BPW        = W / 8;

   logic [RATE_WORDS*W-1:0] buffer_reg;
   logic [CNT_W-1:0]        counter_reg;
   logic [BYTES_W-1:0]      valid_bytes_reg;
   logic [CNT_W-1:0]        final_words;
   logic [BYTES_W-1:0]      tail_bytes;
   logic                    shift_ok;
   logic                    last_word;

   assign shift_ok = bus.output_buffer_shift_en && (counter_reg != '0);

   // A partially filled final word still costs one full output cycle, hence round up.
   assign final_words = CNT_W'(({1'b0, bus.last_bytes_in} + (BYTES_W+1)'(BPW - 1))
                               / (BYTES_W+1)'(BPW));

   always_ff @(posedge clk) begin
      if (rst) begin
         buffer_reg      <= '0;
         counter_reg     <= '0;
         valid_bytes_reg <= '0;
      end else begin
         if (bus.output_buffer_we)
            buffer_reg <= bus.state_in;
         else if (shift_ok)
            buffer_reg <= {{W{1'b0}}, buffer_reg[RATE_WORDS*W-1:W]};

         if (bus.output_counter_rst)
            counter_reg <= '0;
         else if (bus.output_counter_load && bus.valid_bytes_enable)
            counter_reg <= final_words;
         else if (bus.output_counter_load)
            counter_reg <= CNT_W'(RATE_WORDS);
         else if (shift_ok)
            counter_reg <= counter_reg - CNT_W'(1);

         if (bus.valid_bytes_reset)
            valid_bytes_reg <= '0;
         else if (bus.valid_bytes_enable)
            valid_bytes_reg <= bus.last_bytes_in;

         if (bus.valid_bytes_enable)
            assert ((bus.last_bytes_in != '0) && (bus.last_bytes_in <= BYTES_W'(RATE_BYTES)))
               else $error("output_buffer: last_bytes_in out of range");
      end
   end

   assign tail_bytes              = valid_bytes_reg % BYTES_W'(BPW);
   assign last_word               = (counter_reg == CNT_W'(1)) && (valid_bytes_reg != '0);
   assign bus.output_buffer_empty = (counter_reg == '0);
   assign bus.last_out            = last_word;

   // A byte is dropped only on the final word, and only when the block ends mid-word.
   for (genvar gi = 0; gi < BPW; gi++) begin : g_byte
      assign bus.keep_out[gi] = !last_word || (tail_bytes == '0) || (BYTES_W'(gi) < tail_bytes);
`ifdef OUTPUT_BUFFER_ZERO_PAD_EN
      assign bus.data_out[8*gi +: 8] = bus.keep_out[gi] ? buffer_reg[8*gi +: 8] : 8'h00;
`else
      assign bus.data_out[8*gi +: 8] = buffer_reg[8*gi +: 8];
`endif
   end
endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: driver pushes the expected word stream per block, a negedge monitor checks it.
// Expected words come from a block-level model (word list, byte count, optional zero padding).
module tb_output_buffer;
   localparam int W          = 64;
   localparam int RW         = 21;
   localparam int BPW        = W / 8;
   localparam int RATE_BYTES = RW * BPW;
   localparam int BYTES_W    = $clog2(RATE_BYTES + 1);
`ifdef OUTPUT_BUFFER_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_buffer_if #(.W(W), .RATE_WORDS(RW)) bus ();
   output_buffer #(.W(W), .RATE_WORDS(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [W-1:0]   data;
      logic [BPW-1:0] keep;
      logic           last;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] st[RW];
   int           model_vb = 0;
   logic [W-1:0] idle_data;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pad(input logic [W-1:0] d, input logic [BPW-1:0] k);
      logic [W-1:0] r = d;
      for (int b = 0; b < BPW; b++)
         if (PAD_EN && !k[b]) r[8*b +: 8] = 8'h00;
      return r;
   endfunction

   // Monitor: the word on display must match the head of the queue; it is consumed when shift_en is high.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.output_buffer_we === 1'b0 && bus.output_buffer_empty === 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected no word", bus.data_out);
         end else begin
            mon_e = sb[0];
            check("word_data", bus.data_out, mon_e.data);
            check("word_keep", W'(bus.keep_out), W'(mon_e.keep));
            check("word_last", W'(bus.last_out), W'(mon_e.last));
            if (bus.output_buffer_shift_en) void'(sb.pop_front());
         end
      end
   end

   // kind 0: non-final block (valid_bytes_reset), 1: final block of lb bytes, 2: no valid-bytes control.
   task automatic load_block(input int kind, input int lb, input bit ones1, input bit crst);
      int   n;
      exp_t e;
      for (int i = 0; i < RW; i++) st[i] = {$urandom, $urandom};
      if (ones1) st[1] = '1;
      for (int i = 0; i < RW; i++) bus.state_in[i*W +: W] = st[i];
      bus.output_buffer_we    = 1'b1;
      bus.output_counter_load = 1'b1;
      bus.output_counter_rst  = crst;
      bus.valid_bytes_enable  = (kind == 1);
      bus.valid_bytes_reset   = (kind == 0);
      bus.last_bytes_in       = BYTES_W'(lb);
      if (kind == 1) model_vb = lb;
      else if (kind == 0) model_vb = 0;
      n = crst ? 0 : ((kind == 1) ? (lb + BPW - 1) / BPW : RW);
      for (int i = 0; i < n; i++) begin
         e.last = (model_vb != 0) && (i == n - 1);
         e.keep = (e.last && (model_vb % BPW) != 0) ? BPW'((1 << (model_vb % BPW)) - 1) : '1;
         e.data = pad(st[i], e.keep);
         sb.push_back(e);
      end
      idle_data = (n < RW) ? st[n] : '0;
      $display("block: kind=%0d last_bytes=%0d counter_rst=%0d words=%0d", kind, lb, crst, n);
      @(posedge clk);
      #1;
      bus.output_buffer_we    = 1'b0;
      bus.output_counter_load = 1'b0;
      bus.output_counter_rst  = 1'b0;
      bus.valid_bytes_enable  = 1'b0;
      bus.valid_bytes_reset   = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      for (int pass = 0; pass < 2; pass++) begin
         check({tag, "_empty"}, W'(bus.output_buffer_empty), W'(1));
         check({tag, "_idle_data"}, bus.data_out, idle_data);
         check({tag, "_idle_keep"}, W'(bus.keep_out), W'({BPW{1'b1}}));
         check({tag, "_idle_last"}, W'(bus.last_out), W'(0));
         bus.output_buffer_shift_en = (pass == 0);
         repeat (2) @(posedge clk);
         #1;
         bus.output_buffer_shift_en = 1'b0;
      end
   endtask

   // mode 0: shift held, 1: pattern 1,0,0,1, 2: random. abort_after>=0 pulses rst after that many shifts.
   task automatic drain(input int mode, input int abort_after);
      int cyc = 0;
      int acc = 0;
      bit s;
      while (bus.output_buffer_empty !== 1'b1 && cyc < 400) begin
         if (abort_after >= 0 && acc == abort_after) begin
            bus.output_buffer_shift_en = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            sb.delete();
            model_vb  = 0;
            idle_data = '0;
            $display("reset after %0d shifts", acc);
            return;
         end
         case (mode)
            0:       s = 1'b1;
            1:       s = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: s = 1'($urandom_range(0, 1));
         endcase
         bus.output_buffer_shift_en = s;
         @(posedge clk);
         #1;
         if (s) acc++;
         cyc++;
      end
      bus.output_buffer_shift_en = 1'b0;
      if (cyc >= 400) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d cycles required empty before 400", cyc);
      end
      check("words_left", W'(sb.size()), W'(0));
   endtask

   initial begin
      rst                        = 1'b1;
      bus.state_in               = '0;
      bus.output_buffer_we       = 1'b0;
      bus.output_counter_load    = 1'b0;
      bus.output_counter_rst     = 1'b0;
      bus.output_buffer_shift_en = 1'b0;
      bus.valid_bytes_enable     = 1'b0;
      bus.valid_bytes_reset      = 1'b0;
      bus.last_bytes_in          = '0;
      idle_data                  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_check("reset");

      load_block(0, 0, 1'b0, 1'b0);   drain(0, -1); idle_check("t1");
      load_block(1, 20, 1'b0, 1'b0);  drain(0, -1); idle_check("t2");
      load_block(0, 0, 1'b0, 1'b0);   drain(1, -1); idle_check("t3");
      load_block(1, 168, 1'b0, 1'b0); drain(2, -1); idle_check("t4");
      load_block(1, 13, 1'b1, 1'b0);  drain(2, -1); idle_check("t6");
      load_block(1, 100, 1'b0, 1'b0); drain(0, 5);  idle_check("t5");
      load_block(2, 0, 1'b0, 1'b0);   drain(2, -1); idle_check("vb_cleared");
      load_block(0, 0, 1'b0, 1'b1);                 idle_check("counter_rst");

      for (int t = 0; t < 12; t++) begin
         load_block($urandom_range(0, 2), $urandom_range(1, RATE_BYTES), 1'b0, 1'b0);
         drain(2, -1);
         idle_check("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
